// File: rtl/xnor2_unit_pkg.sv
// Shared constants and helpers for the xnor2_unit compare primitive.
package xnor2_unit_pkg;

   localparam int max_width_lp = 64;

   // Bits needed to hold a match count in 0..w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/xnor2_unit_popcount.sv
// Combinational population count, built as a balanced adder tree over a
// power-of-two padded leaf row.
module xnor2_unit_popcount
   import xnor2_unit_pkg::*;
#(
   parameter int width_p = 1
) (
   input  logic [width_p-1:0]               bits_i,
   output logic [cnt_width(width_p)-1:0]    cnt_o
);

   localparam int cnt_w_lp = cnt_width(width_p);
   localparam int lvls_lp  = (width_p > 1) ? $clog2(width_p) : 0;
   localparam int leaves_lp = 1 << lvls_lp;

   // Heap layout: node 1 is the root, leaves sit at leaves_lp..2*leaves_lp-1.
   logic [2*leaves_lp-1:1][cnt_w_lp-1:0] node;

   for (genvar i = 0; i < leaves_lp; i++) begin : g_leaf
      if (i < width_p) begin : g_bit
         assign node[leaves_lp+i] = cnt_w_lp'(bits_i[i]);
      end else begin : g_pad
         assign node[leaves_lp+i] = '0;
      end
   end

   for (genvar n = 1; n < leaves_lp; n++) begin : g_sum
      assign node[n] = node[2*n] + node[2*n+1];
   end

   assign cnt_o = node[1];

endmodule

// File: rtl/xnor2_unit.sv
// Bitwise XNOR with a combinational path and a one-entry registered stage.
// Define XNOR2_UNIT_MATCH_CNT_EN to build the registered match counter.
module xnor2_unit
   import xnor2_unit_pkg::*;
#(
   parameter int width_p = 1
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [width_p-1:0]              a_i,
   input  logic [width_p-1:0]              b_i,
   output logic [width_p-1:0]              c_o,
   input  logic                            v_i,
   output logic                            ready_o,
   output logic                            v_o,
   input  logic                            yumi_i,
   output logic [width_p-1:0]              c_r_o,
   output logic                            eq_o,
   output logic [cnt_width(width_p)-1:0]   match_cnt_o
);

   localparam int cnt_w_lp = cnt_width(width_p);

   if (width_p < 1 || width_p > max_width_lp) begin : g_bad_width
      $error("xnor2_unit: width_p out of range");
   end

   logic [width_p-1:0] xnor_c;
   logic               accept;
   logic               deq;
   logic               v_r;
   logic [width_p-1:0] c_r;
   logic               eq_r;

   assign xnor_c  = ~(a_i ^ b_i);
   assign c_o     = xnor_c;

   // A dequeue in the same cycle frees the slot, so a new pair can land.
   assign ready_o = ~v_r | yumi_i;
   assign accept  = v_i & ready_o;
   assign deq     = yumi_i & v_r;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_r  <= 1'b0;
         c_r  <= '0;
         eq_r <= 1'b0;
      end else if (accept) begin
         v_r  <= 1'b1;
         c_r  <= xnor_c;
         eq_r <= &xnor_c;
      end else if (deq) begin
         v_r  <= 1'b0;
      end
   end

   assign v_o   = v_r;
   assign c_r_o = c_r;
   assign eq_o  = eq_r;

`ifdef XNOR2_UNIT_MATCH_CNT_EN
   logic [cnt_w_lp-1:0] cnt_c;
   logic [cnt_w_lp-1:0] cnt_r;

   xnor2_unit_popcount #(.width_p(width_p)) u_popcount (
      .bits_i (xnor_c),
      .cnt_o  (cnt_c)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i)     cnt_r <= '0;
      else if (accept) cnt_r <= cnt_c;
   end

   assign match_cnt_o = cnt_r;
`else
   assign match_cnt_o = '0;
`endif

endmodule

// File: tb/tb_xnor2_unit.sv
// Self-checking bench for xnor2_unit: width 1 combinational truth table and a
// width 8 instance exercised with directed and random handshake traffic.
module tb_xnor2_unit;

`ifdef XNOR2_UNIT_MATCH_CNT_EN
   localparam bit cnt_on = 1'b1;
`else
   localparam bit cnt_on = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       a1, b1, c1, v1_o, rdy1, cr1, eq1;
   logic       cnt1;
   logic [7:0] a, b, c, cr;
   logic       v, rdy, vo, yumi, eq;
   logic [3:0] cnt;

   int n_pass = 0;
   int n_total = 0;

   xnor2_unit #(.width_p(1)) u_w1 (
      .clk_i(clk), .reset_i(rst), .a_i(a1), .b_i(b1), .c_o(c1),
      .v_i(1'b0), .ready_o(rdy1), .v_o(v1_o), .yumi_i(1'b0),
      .c_r_o(cr1), .eq_o(eq1), .match_cnt_o(cnt1)
   );

   xnor2_unit #(.width_p(8)) u_w8 (
      .clk_i(clk), .reset_i(rst), .a_i(a), .b_i(b), .c_o(c),
      .v_i(v), .ready_o(rdy), .v_o(vo), .yumi_i(yumi),
      .c_r_o(cr), .eq_o(eq), .match_cnt_o(cnt)
   );

   // Reference: a one-slot holding register described by its contract only.
   logic       m_v;
   logic [7:0] m_c;
   logic       m_eq;
   logic [3:0] m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_v <= 1'b0; m_c <= 8'h00; m_eq <= 1'b0; m_cnt <= 4'd0;
      end else if (v && (!m_v || yumi)) begin
         m_v   <= 1'b1;
         m_c   <= ~(a ^ b);
         m_eq  <= (a == b);
         m_cnt <= cnt_on ? 4'($countones(~(a ^ b))) : 4'd0;
      end else if (yumi && m_v) begin
         m_v <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; v = 1'b0; yumi = 1'b0; a = 8'h00; b = 8'h00; a1 = 1'b0; b1 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      n_total++; if (vo !== 1'b0) $display("FAIL reset_v_o got %b want 0", vo); else n_pass++;
      n_total++; if (cr !== 8'h00) $display("FAIL reset_c_r_o got %h want 00", cr); else n_pass++;
      n_total++; if (eq !== 1'b0) $display("FAIL reset_eq_o got %b want 0", eq); else n_pass++;
      n_total++; if (cnt !== 4'd0) $display("FAIL reset_match_cnt got %0d want 0", cnt); else n_pass++;
      n_total++; if (rdy !== 1'b1) $display("FAIL reset_ready got %b want 1", rdy); else n_pass++;
      n_total++; if (v1_o !== 1'b0) $display("FAIL reset_w1_v_o got %b want 0", v1_o); else n_pass++;
   endtask

   task automatic test_comb();
      logic [3:0] want;
      logic [7:0] ra, rb;
      want = 4'b1001;  // index {a,b}: 00->1, 01->0, 10->0, 11->1
      for (int i = 0; i < 4; i++) begin
         a1 = i[1]; b1 = i[0];
         #10;
         n_total++;
         if (c1 !== want[i]) $display("FAIL comb_w1 a=%b b=%b got %b want %b", a1, b1, c1, want[i]);
         else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         a = ra; b = rb;
         #3;
         n_total++;
         if (c !== ~(ra ^ rb)) $display("FAIL comb_w8 a=%h b=%h got %h want %h", ra, rb, c, ~(ra ^ rb));
         else n_pass++;
      end
   endtask

   task automatic test_accept();
      a = 8'hA5; b = 8'hA5; v = 1'b1;
      tick();
      v = 1'b0;
      n_total++; if (vo !== 1'b1) $display("FAIL accept_v_o got %b want 1", vo); else n_pass++;
      n_total++; if (cr !== 8'hFF) $display("FAIL accept_c_r_o got %h want FF", cr); else n_pass++;
      n_total++; if (eq !== 1'b1) $display("FAIL accept_eq got %b want 1", eq); else n_pass++;
      n_total++; if (cnt !== (cnt_on ? 4'd8 : 4'd0)) $display("FAIL accept_cnt got %0d want %0d", cnt, cnt_on ? 8 : 0); else n_pass++;
      yumi = 1'b1;
      tick();
      yumi = 1'b0;
      n_total++; if (vo !== 1'b0) $display("FAIL dequeue_v_o got %b want 0", vo); else n_pass++;
      n_total++; if (cr !== 8'hFF) $display("FAIL dequeue_hold got %h want FF", cr); else n_pass++;
      n_total++; if (cnt !== (cnt_on ? 4'd8 : 4'd0)) $display("FAIL dequeue_cnt_hold got %0d", cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      a = 8'hF0; b = 8'h0F; v = 1'b1;
      tick();
      n_total++; if (cr !== 8'h00) $display("FAIL bp_load got %h want 00", cr); else n_pass++;
      n_total++; if (eq !== 1'b0) $display("FAIL bp_eq got %b want 0", eq); else n_pass++;
      n_total++; if (rdy !== 1'b0) $display("FAIL bp_ready got %b want 0", rdy); else n_pass++;
      a = 8'h00; b = 8'h00;
      tick(); tick();
      v = 1'b0;
      n_total++; if (cr !== 8'h00) $display("FAIL bp_ignore got %h want 00", cr); else n_pass++;
      n_total++; if (eq !== 1'b0) $display("FAIL bp_ignore_eq got %b want 0", eq); else n_pass++;
      n_total++; if (vo !== 1'b1) $display("FAIL bp_v_o got %b want 1", vo); else n_pass++;
   endtask

   task automatic test_simultaneous();
      a = 8'h3C; b = 8'h3D; v = 1'b1; yumi = 1'b1;
      tick();
      v = 1'b0; yumi = 1'b0;
      n_total++; if (vo !== 1'b1) $display("FAIL simul_v_o got %b want 1", vo); else n_pass++;
      n_total++; if (cr !== 8'hFE) $display("FAIL simul_c_r_o got %h want FE", cr); else n_pass++;
      n_total++; if (eq !== 1'b0) $display("FAIL simul_eq got %b want 0", eq); else n_pass++;
      n_total++; if (cnt !== (cnt_on ? 4'd7 : 4'd0)) $display("FAIL simul_cnt got %0d want %0d", cnt, cnt_on ? 7 : 0); else n_pass++;
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; v = 1'b1; a = 8'h55; b = 8'h55;
      tick();
      rst = 1'b0; v = 1'b0;
      n_total++; if (vo !== 1'b0) $display("FAIL rstmid_v_o got %b want 0", vo); else n_pass++;
      n_total++; if (cr !== 8'h00) $display("FAIL rstmid_c_r_o got %h want 00", cr); else n_pass++;
      n_total++; if (eq !== 1'b0) $display("FAIL rstmid_eq got %b want 0", eq); else n_pass++;
      n_total++; if (rdy !== 1'b1) $display("FAIL rstmid_ready got %b want 1", rdy); else n_pass++;
      n_total++; if (cnt !== 4'd0) $display("FAIL rstmid_cnt got %0d want 0", cnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] ra, rb;
      int got = 0;
      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         if (i % 5 == 0) rb = ra;
         a = ra; b = rb; v = 1'b1; yumi = (i > 0);
         tick();
         if (vo === 1'b1) got++;
         n_total++;
         if (vo !== 1'b1 || cr !== ~(ra ^ rb) || eq !== (ra == rb))
            $display("FAIL stream[%0d] v_o=%b c_r_o=%h eq=%b want 1 %h %b", i, vo, cr, eq, ~(ra ^ rb), ra == rb);
         else n_pass++;
      end
      v = 1'b0; yumi = 1'b1;
      tick();
      yumi = 1'b0;
      n_total++; if (got !== 16) $display("FAIL stream_count got %0d want 16", got); else n_pass++;
      n_total++; if (vo !== 1'b0) $display("FAIL stream_drain got %b want 0", vo); else n_pass++;
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         if ($urandom_range(3) == 0) b = a;
         v = 1'($urandom);
         yumi = m_v & 1'($urandom);
         rst = ($urandom_range(60) == 0);
         tick();
         if (vo !== m_v || (m_v && (cr !== m_c || eq !== m_eq || cnt !== m_cnt)) || rdy !== (!m_v || yumi)) begin
            bad++;
            if (bad < 5)
               $display("FAIL random[%0d] dut v=%b c=%h eq=%b cnt=%0d model v=%b c=%h eq=%b cnt=%0d",
                        i, vo, cr, eq, cnt, m_v, m_c, m_eq, m_cnt);
         end
      end
      rst = 1'b0; v = 1'b0; yumi = 1'b0;
      n_total++; if (bad !== 0) $display("FAIL random_total mismatched_cycles=%0d want 0", bad); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_comb();
      test_accept();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/xnor2_unit.md
Name: xnor2_unit

Overview:
- Bitwise XNOR of two equal-width operands.
- Combinational result path: the 1-bit truth table is the primary contract.
- Registered result path: one-entry output stage with valid/ready-style handshake, plus an equality flag.
- Used as a leaf compare/match primitive, e.g. tag compare and equality detect, in datapaths.

Parameters:
- width_p, default 1, operand and result width in bits; legal range 1..64.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_i  input  1  synchronous, active-high reset
- a_i  input  width_p  operand A
- b_i  input  width_p  operand B
- c_o  output  width_p  combinational result, ~(a_i ^ b_i) bitwise
- v_i  input  1  a_i/b_i valid for the registered path
- ready_o  output  1  unit can accept an operand pair this cycle
- v_o  output  1  registered result valid
- yumi_i  input  1  consumer takes the registered result; legal only when v_o=1
- c_r_o  output  width_p  registered XNOR result
- eq_o  output  1  registered flag, 1 when all bits of c_r_o are 1 (a==b)
- match_cnt_o  output  $clog2(width_p+1)  registered count of matching bits; see Optional Feature

Behaviour:
- Interface: single clock clk_i; reset_i is synchronous and active-high.
- c_o is purely combinational, independent of clk_i/reset_i/v_i.
  - 1-bit truth table for c_o: 00->1, 10->0, 01->0, 11->1.
  - No X on c_o for known inputs.
- ready_o = ~v_o | yumi_i (combinational). This gives one-entry storage with same-cycle pass-through on dequeue.
- Accept when v_i & ready_o at a rising edge:
  - c_r_o <= ~(a_i ^ b_i)
  - eq_o <= &(~(a_i ^ b_i))
  - v_o <= 1
  - Latency from accept to v_o is one cycle.
- Dequeue when yumi_i & v_o at a rising edge.
  - With no simultaneous accept: v_o <= 0, and c_r_o/eq_o hold their values.
- Simultaneous yumi_i and accept: new result is loaded and v_o stays 1. Throughput is one per cycle.
- v_i while ready_o=0: input is ignored and not stored. The producer must hold its data.
- yumi_i while v_o=0: illegal. Ignored, with no state change.
- Reset (including mid-operation): at the next edge, v_o=0, c_r_o=0, eq_o=0, match_cnt_o=0. Any pending result is discarded; reset has priority over accept and dequeue.
- width_p=1: eq_o equals c_r_o.

Optional Feature:
- Macro XNOR2_UNIT_MATCH_CNT_EN.
- When defined:
  - match_cnt_o is loaded on accept with the population count of ~(a_i ^ b_i), range 0..width_p.
  - It holds on dequeue and resets to 0.
- When undefined: match_cnt_o is tied to 0 and no popcount logic is built. The port remains present in both configurations.

Decomposition:
- Shared package xnor2_unit_pkg holds:
  - the width_p legal maximum constant (64)
  - the count-width helper function, $clog2(width_p+1)
- One natural sub-module: xnor2_unit_popcount (parameterized width, combinational adder tree). It is instantiated only under XNOR2_UNIT_MATCH_CNT_EN.

Test Plan:
- width_p=1, combinational path: drive each pair for 10ns, then check c_o:
  - a=0,b=0 -> c_o=1
  - a=1,b=0 -> c_o=0
  - a=0,b=1 -> c_o=0
  - a=1,b=1 -> c_o=1
- Registered accept, width_p=8: a=8'hA5, b=8'hA5, v_i=1 for one cycle -> next cycle v_o=1, c_r_o=8'hFF, eq_o=1, match_cnt_o=8 (feature on) or 0 (feature off).
- Backpressure, width_p=8:
  - Load a=8'hF0, b=8'h0F and hold yumi_i=0 -> c_r_o=8'h00, eq_o=0, ready_o=0.
  - Offer a=8'h00, b=8'h00 -> ignored; c_r_o stays 8'h00.
- Simultaneous dequeue+accept: with v_o=1, assert yumi_i=1 and v_i=1 with a=8'h3C, b=8'h3D -> v_o stays 1, c_r_o=8'hFE, eq_o=0, match_cnt_o=7 (feature on).
- Reset mid-operation: with v_o=1, assert reset_i for one cycle together with v_i=1 -> next edge v_o=0, c_r_o=0, eq_o=0, ready_o=1.
- Streaming: 16 back-to-back random pairs with yumi_i=1 every cycle -> one result per cycle, each matching ~(a^b), no drops.
